rc_servo_pulse_decoder: RTL and testbench
=========================================

Name: rc_servo_pulse_decoder

Overview:
Receive-side counterpart of the servo PWM generator. Samples an incoming 50 Hz RC servo pulse train, measures each high-pulse width in clk cycles, and converts it back to the 8-bit position byte. Conversion inverts the generator mapping: width = 50000 + 195*data. Used for loop-back checking of the generator and for reading external RC receivers.

Parameters:
MinWidth, 50000, high-width in clocks that decodes to position 0 (1 ms at 50 MHz)
ClkDiv, 195, clocks per position step
GlitchMin, 1000, high pulses shorter than this are discarded
MaxWidth, 110000, high-width limit; exceeding it means a stuck-high input
FrameTimeout, 1200000, clocks without an accepted pulse before signal_lost is set

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
RCServo_pulse  in  1  asynchronous servo pulse input
pos_data  out  8  last decoded position
pos_valid  out  1  one-cycle strobe when pos_data updates
pulse_width  out  17  last measured high-width in clocks
range_err  out  1  last accepted pulse was shorter than MinWidth or saturated past 255
stuck_high  out  1  input held high longer than MaxWidth
signal_lost  out  1  no accepted pulse within FrameTimeout

Behaviour:
- Input synchronisation: two-flop synchroniser. The edge detector compares the synchronised value s with its previous value s_d.
- Reset values: all outputs 0. FSM state WAIT_LOW. All counters 0.
- States:
  - WAIT_LOW: wait for s=0, then go to WAIT_RISE. Exiting reset or STUCK mid-pulse never measures a partial pulse.
  - WAIT_RISE: on rising edge (s=1, s_d=0), go to MEASURE. Clear width_cnt, step_cnt and pos_cnt.
  - MEASURE, each cycle while s=1:
    - width_cnt increments.
    - Once width_cnt >= MinWidth, step_cnt counts 0..ClkDiv-1. Each wrap increments pos_cnt, saturating at 255. Mark a saturation flag if a wrap occurs with pos_cnt=255.
    - If width_cnt reaches MaxWidth, go to STUCK.
  - MEASURE, falling edge (s=0): width = width_cnt.
    - width < GlitchMin: discard. No output change; go to WAIT_RISE.
    - GlitchMin <= width < MinWidth: pos_data=0, range_err=1, valid.
    - Otherwise: pos_data = pos_cnt = min(255, floor((width-MinWidth)/ClkDiv)). range_err = saturation flag.
    - Every accepted pulse sets pulse_width = width and pulses pos_valid for exactly one cycle (the cycle after the falling edge is seen on s). It also clears signal_lost and stuck_high and restarts the frame counter.
  - STUCK: stuck_high=1; pos_data is held. On s=0, go to WAIT_RISE. stuck_high stays set until the next accepted pulse.
- Width counted: number of cycles s=1, inclusive of the rising-edge cycle. A pulse of N synchronised high cycles gives width N.
- Latency: falling edge at pin to pos_valid is 3–4 clk cycles (synchroniser plus registered output).
- Frame counter: 21-bit, free-running from reset or the last accepted pulse, saturating at FrameTimeout. On reaching FrameTimeout it sets signal_lost=1. It is independent of FSM state, so a stuck-high input also sets signal_lost.
- pos_data and pulse_width are held between valid strobes, including while signal_lost is set.
- Reset asserted mid-pulse: immediate return to reset values. The first pulse after reset is measured only after a low is seen.
- No division hardware: the quotient comes only from the step counter.

Test Plan:
1. Reset, then a pulse of 50000 high cycles with a 20 ms period -> pos_data=0x00, range_err=0, pulse_width=50000, one pos_valid per frame.
2. Pulses of 50000+195*128=74960 and 74960+194 cycles -> pos_data=0x80 both times. A pulse of 75155 cycles -> 0x81.
3. Pulse of 99725 cycles -> 0xFF, range_err=0. Pulse of 100000 cycles -> 0xFF, range_err=1.
4. 500-cycle glitch -> no pos_valid, outputs unchanged. 30000-cycle pulse -> pos_data=0, range_err=1, pos_valid.
5. Input held high for 150000 cycles -> stuck_high=1 at width 110000, no pos_valid. A following valid 74960 pulse -> stuck_high=0, pos_data=0x80.
6. Stop the pulse train for 1.3 M cycles -> signal_lost=1 at 1200000 cycles after the last accepted pulse. Reset asserted mid-pulse -> all outputs 0 and that pulse is not decoded.

Source files
------------

// File: rtl/rc_servo_pulse_decoder.sv
// RC servo pulse decoder: measures each high pulse of a 50 Hz servo train
// and recovers the 8-bit position byte without a divider.
module rc_servo_pulse_decoder #(
  parameter int unsigned MinWidth     = 50000,
  parameter int unsigned ClkDiv       = 195,
  parameter int unsigned GlitchMin    = 1000,
  parameter int unsigned MaxWidth     = 110000,
  parameter int unsigned FrameTimeout = 1200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RCServo_pulse,
  output logic [7:0]  pos_data,
  output logic        pos_valid,
  output logic [16:0] pulse_width,
  output logic        range_err,
  output logic        stuck_high,
  output logic        signal_lost
);

  localparam int StepW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

  localparam logic [16:0]      MIN_W   = 17'(MinWidth);
  localparam logic [16:0]      GLT_W   = 17'(GlitchMin);
  localparam logic [16:0]      MAX_W   = 17'(MaxWidth);
  localparam logic [20:0]      FRAME_T = 21'(FrameTimeout);
  localparam logic [StepW-1:0] STEP_L  = StepW'(ClkDiv - 1);

  typedef enum logic [1:0] {
    WAIT_LOW,
    WAIT_RISE,
    MEASURE,
    STUCK
  } state_t;

  state_t state;

  logic             sync1;
  logic             s;
  logic             s_d;
  logic [16:0]      width_cnt;
  logic [StepW-1:0] step_cnt;
  logic [7:0]       pos_cnt;
  logic             sat;
  logic [20:0]      frame_cnt;
  logic [16:0]      width_nx;

  assign width_nx = width_cnt + 17'd1;

  // Synchroniser resets high so a pulse in flight at reset release is
  // never mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= 1'b1;
      s           <= 1'b1;
      s_d         <= 1'b1;
      state       <= WAIT_LOW;
      width_cnt   <= '0;
      step_cnt    <= '0;
      pos_cnt     <= '0;
      sat         <= 1'b0;
      frame_cnt   <= '0;
      pos_data    <= '0;
      pos_valid   <= 1'b0;
      pulse_width <= '0;
      range_err   <= 1'b0;
      stuck_high  <= 1'b0;
      signal_lost <= 1'b0;
    end else begin
      sync1     <= RCServo_pulse;
      s         <= sync1;
      s_d       <= s;
      pos_valid <= 1'b0;

      if (frame_cnt < FRAME_T) begin
        frame_cnt <= frame_cnt + 21'd1;
        if (frame_cnt == FRAME_T - 21'd1)
          signal_lost <= 1'b1;
      end

      unique case (state)
        WAIT_LOW: begin
          if (!s)
            state <= WAIT_RISE;
        end
        WAIT_RISE: begin
          if (s && !s_d) begin
            state     <= MEASURE;
            width_cnt <= 17'd1;
            step_cnt  <= '0;
            pos_cnt   <= '0;
            sat       <= 1'b0;
          end
        end
        MEASURE: begin
          if (s) begin
            width_cnt <= width_nx;
            if (width_cnt >= MIN_W) begin
              if (step_cnt == STEP_L) begin
                step_cnt <= '0;
                if (pos_cnt == 8'hFF)
                  sat <= 1'b1;
                else
                  pos_cnt <= pos_cnt + 8'd1;
              end else begin
                step_cnt <= step_cnt + 1'b1;
              end
            end
            if (width_nx == MAX_W) begin
              state      <= STUCK;
              stuck_high <= 1'b1;
            end
          end else begin
            state <= WAIT_RISE;
            if (width_cnt >= GLT_W) begin
              pos_valid   <= 1'b1;
              pulse_width <= width_cnt;
              stuck_high  <= 1'b0;
              signal_lost <= 1'b0;
              frame_cnt   <= '0;
              if (width_cnt < MIN_W) begin
                pos_data  <= 8'h00;
                range_err <= 1'b1;
              end else begin
                pos_data  <= pos_cnt;
                range_err <= sat;
              end
            end
          end
        end
        STUCK: begin
          if (!s)
            state <= WAIT_RISE;
        end
        default: state <= WAIT_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_rc_servo_pulse_decoder.sv
// Bench for rc_servo_pulse_decoder with scaled timing parameters;
// expectations come from an arithmetic model of the width-to-position rule.
module tb_rc_servo_pulse_decoder;

  localparam int MINW  = 500;
  localparam int DIV   = 5;
  localparam int GLT   = 100;
  localparam int MAXW  = 1900;
  localparam int FRAME = 6000;
  localparam int GAP   = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        RCServo_pulse;
  logic [7:0]  pos_data;
  logic        pos_valid;
  logic [16:0] pulse_width;
  logic        range_err;
  logic        stuck_high;
  logic        signal_lost;

  int errors = 0;
  int checks = 0;

  int          valid_cnt = 0;
  int          cyc = 0;
  int          last_valid_cyc = 0;
  logic [7:0]  cap_pos;
  logic        cap_err;
  logic [16:0] cap_width;

  int          exp_pos = 0;
  int          exp_err = 0;
  int          exp_width = 0;
  int          exp_stuck = 0;

  rc_servo_pulse_decoder #(
    .MinWidth(MINW),
    .ClkDiv(DIV),
    .GlitchMin(GLT),
    .MaxWidth(MAXW),
    .FrameTimeout(FRAME)
  ) dut (
    .clk(clk),
    .reset(reset),
    .RCServo_pulse(RCServo_pulse),
    .pos_data(pos_data),
    .pos_valid(pos_valid),
    .pulse_width(pulse_width),
    .range_err(range_err),
    .stuck_high(stuck_high),
    .signal_lost(signal_lost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pos_valid) begin
      valid_cnt      <= valid_cnt + 1;
      cap_pos        <= pos_data;
      cap_err        <= range_err;
      cap_width      <= pulse_width;
      last_valid_cyc <= cyc;
    end
  end

  task automatic pulse_check(input string name, input int n);
    int vc0;
    int acc;
    int q;
    vc0 = valid_cnt;
    RCServo_pulse = 1'b1;
    repeat (n) @(negedge clk);
    RCServo_pulse = 1'b0;
    repeat (GAP) @(negedge clk);
    acc = 0;
    if (n >= MAXW) begin
      exp_stuck = 1;
    end else if (n >= GLT) begin
      acc = 1;
      exp_width = n;
      exp_stuck = 0;
      if (n < MINW) begin
        exp_pos = 0;
        exp_err = 1;
      end else begin
        q = (n - MINW) / DIV;
        exp_pos = (q > 255) ? 255 : q;
        exp_err = (q > 255) ? 1 : 0;
      end
    end
    checks++;
    if (valid_cnt - vc0 !== acc) begin
      errors++;
      $display("FAIL %s valid_count: got %0d want %0d", name, valid_cnt - vc0, acc);
    end
    if (acc == 1) begin
      checks++;
      if (cap_pos !== 8'(exp_pos) || cap_err !== 1'(exp_err) ||
          cap_width !== 17'(exp_width)) begin
        errors++;
        $display("FAIL %s strobe: got pos=%0d err=%0d w=%0d want pos=%0d err=%0d w=%0d",
                 name, cap_pos, cap_err, cap_width, exp_pos, exp_err, exp_width);
      end
      checks++;
      if (signal_lost !== 1'b0) begin
        errors++;
        $display("FAIL %s signal_lost: got %0d want 0", name, signal_lost);
      end
    end
    checks++;
    if (pos_data !== 8'(exp_pos) || range_err !== 1'(exp_err) ||
        pulse_width !== 17'(exp_width) || stuck_high !== 1'(exp_stuck)) begin
      errors++;
      $display("FAIL %s held: got pos=%0d err=%0d w=%0d stuck=%0d want %0d %0d %0d %0d",
               name, pos_data, range_err, pulse_width, stuck_high,
               exp_pos, exp_err, exp_width, exp_stuck);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    RCServo_pulse = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({pos_data, pos_valid, pulse_width, range_err, stuck_high, signal_lost} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got pos=%0d v=%0d w=%0d err=%0d stuck=%0d lost=%0d want all 0",
               pos_data, pos_valid, pulse_width, range_err, stuck_high, signal_lost);
    end
    reset = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic test_min_width();
    pulse_check("min_width_a", MINW);
    pulse_check("min_width_b", MINW);
  endtask

  task automatic test_steps();
    pulse_check("pos_0x80", MINW + DIV * 128);
    pulse_check("pos_0x80_top", MINW + DIV * 128 + DIV - 1);
    pulse_check("pos_0x81", MINW + DIV * 129);
  endtask

  task automatic test_top();
    pulse_check("pos_0xff", MINW + DIV * 255);
    pulse_check("pos_sat", MINW + DIV * 256);
  endtask

  task automatic test_glitch();
    pulse_check("glitch", GLT / 2);
    pulse_check("glitch_edge", GLT - 1);
    pulse_check("glitch_min", GLT);
    pulse_check("short_pulse", 300);
  endtask

  task automatic test_stuck();
    int vc0;
    vc0 = valid_cnt;
    RCServo_pulse = 1'b1;
    repeat (MAXW + 1) @(negedge clk);
    checks++;
    if (stuck_high !== 1'b0) begin
      errors++;
      $display("FAIL stuck_early: got %0d want 0", stuck_high);
    end
    @(negedge clk);
    checks++;
    if (stuck_high !== 1'b1) begin
      errors++;
      $display("FAIL stuck_at_max: got %0d want 1", stuck_high);
    end
    repeat (2500 - MAXW - 2) @(negedge clk);
    RCServo_pulse = 1'b0;
    repeat (GAP) @(negedge clk);
    exp_stuck = 1;
    checks++;
    if (valid_cnt !== vc0 || stuck_high !== 1'b1) begin
      errors++;
      $display("FAIL stuck_hold: got strobes=%0d stuck=%0d want 0 1", valid_cnt - vc0, stuck_high);
    end
    pulse_check("after_stuck", MINW + DIV * 128);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      pulse_check("random", int'($urandom_range(50, 1950)));
  endtask

  task automatic test_signal_lost();
    int lim;
    pulse_check("pre_lost", MINW + DIV * 128);
    lim = 0;
    while (cyc < last_valid_cyc + FRAME - 1 && lim < 2 * FRAME) begin
      @(negedge clk);
      lim++;
    end
    checks++;
    if (signal_lost !== 1'b0 || lim >= 2 * FRAME) begin
      errors++;
      $display("FAIL lost_early: got %0d want 0 (wait %0d)", signal_lost, lim);
    end
    @(negedge clk);
    checks++;
    if (signal_lost !== 1'b1) begin
      errors++;
      $display("FAIL lost_at_timeout: got %0d want 1", signal_lost);
    end
    repeat (100) @(negedge clk);
    checks++;
    if (signal_lost !== 1'b1 || pos_data !== 8'h80 || pulse_width !== 17'(MINW + DIV * 128)) begin
      errors++;
      $display("FAIL lost_hold: got lost=%0d pos=%0d w=%0d want 1 128 %0d",
               signal_lost, pos_data, pulse_width, MINW + DIV * 128);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int vc0;
    vc0 = valid_cnt;
    RCServo_pulse = 1'b1;
    repeat (300) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({pos_data, pos_valid, pulse_width, range_err, stuck_high, signal_lost} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got pos=%0d w=%0d err=%0d lost=%0d want 0",
               pos_data, pulse_width, range_err, signal_lost);
    end
    reset = 1'b0;
    repeat (700) @(negedge clk);
    RCServo_pulse = 1'b0;
    repeat (GAP) @(negedge clk);
    checks++;
    if (valid_cnt !== vc0 || pos_data !== 8'h00 || pulse_width !== 17'd0) begin
      errors++;
      $display("FAIL mid_reset_partial: got strobes=%0d pos=%0d w=%0d want 0 0 0",
               valid_cnt - vc0, pos_data, pulse_width);
    end
    exp_pos = 0;
    exp_err = 0;
    exp_width = 0;
    exp_stuck = 0;
    pulse_check("after_mid_reset", MINW + DIV * 129);
  endtask

  initial begin
    reset = 1'b1;
    RCServo_pulse = 1'b0;
    test_reset();
    test_min_width();
    test_steps();
    test_top();
    test_glitch();
    test_stuck();
    test_random();
    test_signal_lost();
    test_reset_mid_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
